// File: rtl/phy_traffic_gen_chk.sv
// Patterned burst generator for the PHY transmit side plus a self-checker for the receive side.
// Define PHY_GEN_CROSSCHK_EN to also cross-compare behavioural and synthesized PHY outputs.
module phy_traffic_gen_chk #(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int GAP_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [1:0]                       mode,
  input  logic [$clog2(BURST_MAX+1)-1:0]   burst_len,
  input  logic [GAP_W-1:0]                 gap_len,
  input  logic [7:0]                       num_bursts,
  output logic [DATA_W-1:0]                data_in_tx,
  output logic                             valid_in_tx,
  input  logic                             valid_out,
  input  logic [DATA_W-1:0]                data_out,
  input  logic                             valid_out_sintetizado,
  input  logic [DATA_W-1:0]                data_out_sintetizado,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_W-1:0]                 rx_count,
  output logic [CNT_W-1:0]                 err_count,
  output logic                             mismatch
);

  localparam int BL_W   = $clog2(BURST_MAX+1);
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_nxt;

  logic [1:0]        mode_q;
  logic [BL_W-1:0]   bl_q, word_cnt, bl_clamped;
  logic [GAP_W-1:0]  gap_q, gap_cnt;
  logic [7:0]        nb_q, burst_idx;
  logic [DATA_W-1:0] tx_pat, rx_pat;
  logic              cfg_zero, last_word, last_burst, gap_over;
  logic              start_run, zero_run, emit_word, begin_burst, enter_gap, finish_run;
  logic              ref_err, cross_err, err_now;

  function automatic logic [DATA_W-1:0] pat_seed(input logic [1:0] m);
    case (m)
      2'd0:    pat_seed = {NBYTES{8'hFF}};
      2'd2:    pat_seed = DATA_W'(1);
      default: pat_seed = '0;
    endcase
  endfunction

  // Mode 0 keeps every byte equal, so the low byte alone determines the next word.
  function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] m, input logic [DATA_W-1:0] p);
    logic [7:0] b;
    b = (p[7:0] == 8'h00) ? 8'hFF : (p[7:0] - 8'h11);
    case (m)
      2'd0:    pat_next = {NBYTES{b}};
      2'd2:    pat_next = {p[DATA_W-2:0], p[DATA_W-1]};
      default: pat_next = p + DATA_W'(1);
    endcase
  endfunction

  assign bl_clamped = (burst_len > BL_W'(BURST_MAX)) ? BL_W'(BURST_MAX) : burst_len;
  assign cfg_zero   = (bl_clamped == '0) || (num_bursts == 8'd0);
  assign last_word  = (word_cnt == bl_q);
  assign last_burst = (burst_idx == (nb_q - 8'd1));
  assign gap_over   = (gap_cnt == gap_q);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !cfg_zero) state_nxt = SEND;
      SEND: if (last_word) begin
              if (last_burst)       state_nxt = IDLE;
              else if (gap_q == '0) state_nxt = SEND;
              else                  state_nxt = GAP;
            end
      GAP:  if (gap_over) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_run   = 1'b0;
    zero_run    = 1'b0;
    emit_word   = 1'b0;
    begin_burst = 1'b0;
    enter_gap   = 1'b0;
    finish_run  = 1'b0;
    case (state)
      IDLE: if (start) begin
              zero_run  = cfg_zero;
              start_run = !cfg_zero;
            end
      SEND: if (!last_word)          emit_word = 1'b1;
            else if (last_burst)     finish_run = 1'b1;
            else if (gap_q == '0) begin
              emit_word   = 1'b1;
              begin_burst = 1'b1;
            end
            else                     enter_gap = 1'b1;
      GAP:  if (gap_over) begin
              emit_word   = 1'b1;
              begin_burst = 1'b1;
            end
      default: ;
    endcase
  end

  // tx_pat always holds the word that will be emitted next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= '0;
      bl_q        <= '0;
      gap_q       <= '0;
      nb_q        <= '0;
      word_cnt    <= '0;
      burst_idx   <= '0;
      gap_cnt     <= '0;
      tx_pat      <= {NBYTES{8'hFF}};
      data_in_tx  <= '0;
      valid_in_tx <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (start_run || zero_run) begin
        mode_q <= mode;
        bl_q   <= bl_clamped;
        gap_q  <= gap_len;
        nb_q   <= num_bursts;
        tx_pat <= pat_seed(mode);
      end
      if (start_run) begin
        data_in_tx  <= pat_seed(mode);
        tx_pat      <= pat_next(mode, pat_seed(mode));
        valid_in_tx <= 1'b1;
        word_cnt    <= BL_W'(1);
        burst_idx   <= '0;
      end else if (emit_word) begin
        data_in_tx  <= tx_pat;
        tx_pat      <= pat_next(mode_q, tx_pat);
        valid_in_tx <= 1'b1;
        word_cnt    <= begin_burst ? BL_W'(1) : (word_cnt + BL_W'(1));
        if (begin_burst) burst_idx <= burst_idx + 8'd1;
      end else begin
        valid_in_tx <= 1'b0;
      end
      if (enter_gap)          gap_cnt <= GAP_W'(1);
      else if (state == GAP)  gap_cnt <= gap_cnt + GAP_W'(1);
      if (start_run)                   done <= 1'b0;
      else if (zero_run || finish_run) done <= 1'b1;
    end
  end

  assign ref_err = valid_out && (data_out != rx_pat);

`ifdef PHY_GEN_CROSSCHK_EN
  assign cross_err = (valid_out != valid_out_sintetizado) ||
                     (valid_out && valid_out_sintetizado && (data_out != data_out_sintetizado));
`else
  logic unused_sintetizado;
  assign unused_sintetizado = ^{valid_out_sintetizado, data_out_sintetizado};
  assign cross_err = 1'b0;
`endif

  assign err_now = ref_err || cross_err;

  // The reference generator advances only on received words, so PHY latency never matters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_pat    <= {NBYTES{8'hFF}};
      rx_count  <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
    end else if (start_run || zero_run) begin
      rx_pat    <= pat_seed(mode);
      rx_count  <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
    end else begin
      if (valid_out) begin
        rx_pat <= pat_next(mode_q, rx_pat);
        if (rx_count != '1) rx_count <= rx_count + CNT_W'(1);
      end
      mismatch <= err_now;
      if (err_now && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
